// File: rtl/score_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, the nibble width and the elaboration-time sizing helpers.
package score_bcd_pkg;

  localparam int unsigned BCD_NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // True when DIGITS decimal digits can represent every WIDTH-bit value.
  function automatic bit bcd_fits(input int unsigned width, input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    max_bin = (64'd1 << width) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3
  import score_bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nib_in,
  output logic [BCD_NIBBLE-1:0] nib_out
);

  always_comb begin
    nib_out = nib_in;
    if (nib_in >= 4'd5) begin
      nib_out = nib_in + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd.sv
// Iterative shift-add-3 binary-to-BCD converter with registered, glitch-free digit outputs.
// Restarts automatically when the input differs from the last converted value.
module score_bcd
  import score_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           i_value,
  output logic [BCD_NIBBLE*DIGITS-1:0] o_bcd,
  output logic [DIGITS-1:0]          o_digit_en,
  output logic                       o_valid,
  output logic                       o_busy
);

  localparam int unsigned AccW = BCD_NIBBLE * DIGITS;
  localparam int unsigned CntW = cnt_width(WIDTH);

  if (!bcd_fits(WIDTH, DIGITS)) begin : g_bad_params
    $error("score_bcd: DIGITS too small to represent every WIDTH-bit value");
  end

  bcd_state_t          state_q, state_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [AccW-1:0]     acc_corr;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AccW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [DIGITS-1:0]   en_calc;
  logic                valid_q, valid_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (acc_q[g*BCD_NIBBLE +: BCD_NIBBLE]),
      .nib_out (acc_corr[g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  // Digit k is shown if it or any more significant digit is nonzero.
  always_comb begin
    en_calc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      en_calc[k] = |(acc_q >> (BCD_NIBBLE * k));
    end
    en_calc[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    en_d    = en_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_value != last_q) begin
          last_d  = i_value;
          shift_d = i_value;
          acc_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shift_d} = {acc_corr, shift_q} << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = acc_q;
        en_d    = en_calc;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      en_q    <= DIGITS'(1);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      valid_q <= valid_d;
    end
  end

  assign o_bcd      = bcd_q;
  assign o_digit_en = en_q;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_score_bcd.sv
// Randomized self-checking bench for score_bcd against a decimal arithmetic reference model.
module tb_score_bcd;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_value;
  logic [11:0] o_bcd;
  logic [2:0]  o_digit_en;
  logic        o_valid;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: last value the DUT has latched and last published result.
  int          last_val = 0;
  logic [11:0] shown_bcd = 12'h000;

  score_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_value    (i_value),
    .o_bcd      (o_bcd),
    .o_digit_en (o_digit_en),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_en(input int v);
    return {v >= 100, v >= 10, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges after E0 until o_valid is seen; also watches hold and overlap rules.
  task automatic wait_valid(output int edges, output bit held_ok, output bit overlap);
    edges   = 0;
    held_ok = 1'b1;
    overlap = 1'b0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (o_valid && o_busy) overlap = 1'b1;
      if (o_valid) break;
      if (o_bcd !== shown_bcd) held_ok = 1'b0;
    end
  endtask

  task automatic run_conv(input int v, input string tag);
    int edges;
    bit held_ok;
    bit overlap;
    @(negedge clk);
    i_value = 8'(v);
    @(posedge clk);  // E0
    wait_valid(edges, held_ok, overlap);
    check({tag, "_latency"}, 32'(edges), 32'd9);
    check({tag, "_bcd"}, 32'(o_bcd), 32'(ref_bcd(v)));
    check({tag, "_en"}, 32'(o_digit_en), 32'(ref_en(v)));
    check({tag, "_held_busy"}, {31'd0, held_ok & ~overlap}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    last_val  = v;
    shown_bcd = ref_bcd(v);
  endtask

  initial begin
    int cnt;
    int e, e1, e2;
    logic [11:0] b1, b2;
    bit held_ok, overlap, busy_seen;
    int v;

    rst_n   = 1'b0;
    i_value = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_bcd", 32'(o_bcd), 32'h000);
    check("rst_en", 32'(o_digit_en), 32'h1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (o_valid) cnt++;
    end
    check("rst_no_valid", 32'(cnt), 32'd0);

    // Max value and single pulse
    run_conv(255, "max");
    cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (o_valid) cnt++;
    end
    check("max_one_pulse", 32'(cnt), 32'd0);

    run_conv(99, "c99");
    run_conv(100, "c100");

    for (int i = 0; i < 256; i++) begin
      if (i != last_val) run_conv(i, "sweep");
    end
    for (int i = 0; i < 150; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == last_val) v = (v + 1) % 256;
      run_conv(v, "rand");
    end

    // Input changes while busy: 37 first, then 42 after E3
    @(negedge clk);
    i_value = 8'd37;
    @(posedge clk);  // E0
    e = 0; e1 = 0; e2 = 0; b1 = '0; b2 = '0;
    while (e < 40 && e2 == 0) begin
      @(posedge clk);
      #1;
      e++;
      if (e == 3) i_value = 8'd42;
      if (o_valid && e1 == 0) begin
        e1 = e; b1 = o_bcd;
      end else if (o_valid) begin
        e2 = e; b2 = o_bcd;
      end
    end
    check("busy_first_edge", 32'(e1), 32'd9);
    check("busy_first_bcd", 32'(b1), 32'h037);
    check("busy_second_edge", 32'(e2), 32'd19);
    check("busy_second_bcd", 32'(b2), 32'h042);
    last_val  = 42;
    shown_bcd = 12'h042;

    // Asynchronous reset mid-conversion
    @(negedge clk);
    i_value = 8'd200;
    @(posedge clk);  // E0
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_bcd", 32'(o_bcd), 32'h000);
    check("arst_en", 32'(o_digit_en), 32'h1);
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_val  = 0;
    shown_bcd = 12'h000;
    @(posedge clk);  // E0 of fresh conversion
    wait_valid(e, held_ok, overlap);
    check("arst_redo_edge", 32'(e), 32'd9);
    check("arst_redo_bcd", 32'(o_bcd), 32'h200);
    check("arst_redo_en", 32'(o_digit_en), 32'h7);
    last_val  = 200;
    shown_bcd = 12'h200;

    // Stable input: one conversion, then silence
    run_conv(7, "stable");
    cnt = 0;
    busy_seen = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (o_valid) cnt++;
      if (o_busy) busy_seen = 1'b1;
    end
    check("stable_no_valid", 32'(cnt), 32'd0);
    check("stable_no_busy", {31'd0, busy_seen}, 32'd0);
    check("stable_bcd", 32'(o_bcd), 32'h007);
    check("stable_en", 32'(o_digit_en), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_bcd.md
# score_bcd

Sequential binary-to-BCD converter between `score_evaluation` (score, 8-bit binary) or `countdown_timer` (seconds) and the digit consumers (`seven_display`, `vga_display`). It replaces the combinational `%`/`/` digit extraction with an iterative shift-add-3 (double-dabble) engine. Conversion restarts automatically whenever the input value changes. Registered digit outputs never glitch mid-conversion.

## Interface
Parameters:
- `WIDTH`, 8: binary input width.
- `DIGITS`, 3: BCD digits produced. Elaboration must fail unless 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`, in, 1: system clock; one clock domain.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `i_value`, in, WIDTH: binary value to convert (score or seconds).
- `o_bcd`, out, 4*DIGITS: packed digits. Nibble 0 = ones, nibble DIGITS−1 = most significant.
- `o_digit_en`, out, DIGITS: leading-zero mask. Bit k = 1 if digit k or any higher digit is nonzero. Bit 0 is always 1.
- `o_valid`, out, 1: one-cycle pulse when `o_bcd` and `o_digit_en` take a new result.
- `o_busy`, out, 1: high while state ≠ IDLE.

## Operation
- Reset values:
  - `o_bcd` = 0, `o_digit_en` = 1 (bit 0 only), `o_valid` = 0, `o_busy` = 0.
  - State IDLE, latched value `last` = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If `i_value` ≠ `last`: latch `i_value` into `last` and into a shift register, clear the BCD accumulator, load the count with WIDTH, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle:
  - Each accumulator nibble ≥ 5 gets +3.
  - Then shift {accumulator, shift register} left by one.
  - Decrement the count. After the WIDTH-th shift, go to DONE.
- DONE:
  - Copy the accumulator to `o_bcd`.
  - Compute `o_digit_en` from the accumulator.
  - Pulse `o_valid`, then go to IDLE.
- Input changes while busy:
  - Ignored until IDLE. IDLE then compares against `last` and starts a new conversion.
  - Only the value captured at IDLE is converted. The final output always matches the settled input.
- Reset mid-conversion: all state returns to reset values immediately (asynchronous). No `o_valid` is produced for the aborted conversion.
- Width rules:
  - Accumulator is 4*DIGITS bits.
  - The count is wide enough to hold WIDTH.
  - The +3 correction is 4-bit; no carry out of a nibble is possible for legal parameters.

## Timing
- Sample edge E0: IDLE sees `i_value` ≠ `last`.
- Edges E1..E(WIDTH): shifts.
- Edge E(WIDTH+1): `o_bcd` updates and `o_valid` = 1 for the following cycle.
- Latency: WIDTH+1 edges from capture, i.e. 9 for WIDTH = 8.
- `o_busy`: high from after E0 until after E(WIDTH+1).
- `o_valid` drops on the next edge. `o_valid` and `o_busy` are never high together.
- Back-to-back: a new value present at E(WIDTH+1) is captured at E(WIDTH+2). The minimum conversion period is WIDTH+2 cycles.
- `o_bcd` holds its previous result throughout SHIFT.

## Structure
- Package `score_bcd_pkg`:
  - State enum `bcd_state_t` (IDLE, SHIFT, DONE).
  - Localparam `BCD_NIBBLE = 4`.
  - Helper function for the counter width (clog2 of WIDTH+1).
- Sub-module `bcd_add3`: combinational 4-bit "≥5 then +3" nibble corrector. Instantiate DIGITS times in a generate loop.

## Test plan
- Reset: assert `rst_n` = 0, release, hold `i_value` = 0 → `o_bcd` = 0x000, `o_digit_en` = 3'b001, no `o_valid` within 20 cycles.
- Max value: `i_value` 0→255 → `o_bcd` = 0x255 at E9, `o_digit_en` = 3'b111, exactly one `o_valid` pulse.
- Carry boundary: 99 then 100 after `o_valid` → results 0x099 with en 3'b011, then 0x100 with en 3'b111. Sweep 0..255 against a reference model.
- Change during busy: 37 applied, then 42 at E3 → first `o_valid` shows 0x037. Second conversion starts at E10, `o_valid` at E19 shows 0x042.
- Reset mid-conversion: `i_value` = 200, `rst_n` low at E4 → outputs zero asynchronously and `o_busy` = 0. After release, a fresh conversion yields 0x200.
- Stable input: hold `i_value` = 7 for 100 cycles after conversion → single `o_valid`, `o_busy` stays 0.
